// File: rtl/hv_feeder_if.sv
// Feature-stream handshake between the raw feature source and hv_feeder.
// The source drives valid/feature/last; the feeder answers with ready.
interface hv_feeder_if #(
    parameter int FEAT_W = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [FEAT_W-1:0] in_feat;
    logic              in_last;

    modport master (output in_valid, output in_feat, output in_last, input  in_ready);
    modport slave  (input  in_valid, input  in_feat, input  in_last, output in_ready);
endinterface

// File: rtl/hv_feeder.sv
// Upstream stage of the HDC classifier: raw features -> value/position hypervectors
// plus encoder clear/enable pulses. Optional protocol checker: HV_FEEDER_PROTO_CHK_EN.
module hv_feeder #(
    parameter int              DIM      = 1024,
    parameter int              FEAT_W   = 8,
    parameter int              LEVELS   = 16,
    parameter int              FEAT_NUM = 64,
    parameter int              SET_SIZE = 8,
    parameter int              GAP_CYC  = 2,
    parameter logic [DIM-1:0]  LVL_SEED = {(DIM/16){16'hA5A5}},
    parameter logic [DIM-1:0]  POS_SEED = {(DIM/16){16'h3C3C}},
    localparam int             SIDX_W   = (SET_SIZE > 1) ? $clog2(SET_SIZE) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              set_start,
    hv_feeder_if.slave        fin,
    output logic [DIM-1:0]    im_value,
    output logic [DIM-1:0]    im_pos,
    output logic              smp_en,
    output logic              smp_clr,
    output logic              set_clr,
    output logic              busy,
    output logic [SIDX_W-1:0] smp_idx
`ifdef HV_FEEDER_PROTO_CHK_EN
    ,
    output logic              proto_err
`endif
);
    localparam int LW   = $clog2(LEVELS);
    localparam int FW   = (FEAT_NUM > 1) ? $clog2(FEAT_NUM) : 1;
    localparam int GW   = $clog2(GAP_CYC + 1);
    localparam int STEP = DIM / (2 * LEVELS);

    typedef enum logic [1:0] {S_IDLE, S_CLR, S_STREAM, S_GAP} state_t;

    state_t             state_q, state_d;
    logic [FW-1:0]      feat_idx_q, feat_idx_d;
    logic [SIDX_W-1:0]  smp_idx_q, smp_idx_d;
    logic [GW-1:0]      gap_q, gap_d;
    logic [DIM-1:0]     value_q, value_d;
    logic [DIM-1:0]     pos_q, pos_d;
    logic               smp_en_q, smp_en_d;
    logic               hs;
    logic               last_feat;
    logic [LW-1:0]      lvl;
    logic [2*DIM-1:0]   pos_rot;

    assign hs        = fin.in_valid && (state_q == S_STREAM);
    assign last_feat = (feat_idx_q == FW'(FEAT_NUM - 1));

    always_comb begin
        state_d    = state_q;
        feat_idx_d = feat_idx_q;
        smp_idx_d  = smp_idx_q;
        gap_d      = gap_q;
        value_d    = value_q;
        pos_d      = pos_q;
        smp_en_d   = hs;
        lvl        = LW'(fin.in_feat >> (FEAT_W - LW));
        // Doubled seed shifted left: upper half is the cyclic rotation.
        pos_rot    = {POS_SEED, POS_SEED} << (int'(feat_idx_q) % DIM);

        if (hs) begin
            value_d = LVL_SEED ^ ~({DIM{1'b1}} << (int'(lvl) * STEP));
            pos_d   = pos_rot[2*DIM-1:DIM];
        end

        case (state_q)
            S_IDLE: begin
                if (set_start) begin
                    state_d   = S_CLR;
                    smp_idx_d = '0;
                end
            end
            S_CLR: begin
                state_d    = S_STREAM;
                feat_idx_d = '0;
            end
            S_STREAM: begin
                // in_last is advisory; only the feature counter closes a sample.
                if (hs) begin
                    if (last_feat) begin
                        state_d    = S_GAP;
                        feat_idx_d = '0;
                        gap_d      = '0;
                    end else begin
                        feat_idx_d = feat_idx_q + FW'(1);
                    end
                end
            end
            S_GAP: begin
                if (gap_q == GW'(GAP_CYC - 1)) begin
                    if (smp_idx_q == SIDX_W'(SET_SIZE - 1)) begin
                        state_d   = S_IDLE;
                        smp_idx_d = '0;
                    end else begin
                        state_d   = S_CLR;
                        smp_idx_d = smp_idx_q + SIDX_W'(1);
                    end
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            feat_idx_q <= '0;
            smp_idx_q  <= '0;
            gap_q      <= '0;
            value_q    <= '0;
            pos_q      <= '0;
            smp_en_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            feat_idx_q <= feat_idx_d;
            smp_idx_q  <= smp_idx_d;
            gap_q      <= gap_d;
            value_q    <= value_d;
            pos_q      <= pos_d;
            smp_en_q   <= smp_en_d;
        end
    end

    assign fin.in_ready = (state_q == S_STREAM);
    assign busy         = (state_q != S_IDLE);
    assign smp_clr      = (state_q == S_CLR);
    assign set_clr      = (state_q == S_CLR) && (smp_idx_q == '0);
    assign smp_en       = smp_en_q;
    assign im_value     = value_q;
    assign im_pos       = pos_q;
    assign smp_idx      = smp_idx_q;

`ifdef HV_FEEDER_PROTO_CHK_EN
    logic proto_err_q, proto_err_d;

    always_comb begin
        proto_err_d = proto_err_q | (hs && (fin.in_last != last_feat));
    end

    always_ff @(posedge clk) begin
        if (rst) proto_err_q <= 1'b0;
        else     proto_err_q <= proto_err_d;
    end

    assign proto_err = proto_err_q;
`else
    logic unused_in_last;
    assign unused_in_last = fin.in_last;
`endif
endmodule

// File: doc/hv_feeder.md
Name: hv_feeder

Overview:
- Upstream stage of the HDC classifier core. Turns a stream of raw scalar features into per-feature value and position hypervectors, plus the encoder control pulses.
- Value HV: level quantisation of the feature, then thermometer bit-flips of a level seed.
- Position HV: cyclic rotation of a position seed by the feature index.
- Drives im_value, im_pos, smp_en, smp_clr and set_clr of the classifier core, sequencing SET_SIZE samples of FEAT_NUM features each.

Parameters:
- DIM, 1024, hypervector width in bits.
- FEAT_W, 8, raw feature width.
- LEVELS, 16, number of quantisation levels (power of 2, ≤ 2^FEAT_W).
- FEAT_NUM, 64, features per sample (equals the core's sample size).
- SET_SIZE, 8, samples per training set.
- GAP_CYC, 2, idle cycles after a sample's last feature so the downstream encoders can finish (≥1).
- LVL_SEED, DIM'h…A5A5, level-0 seed HV.
- POS_SEED, DIM'h…3C3C, position-0 seed HV.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- set_start  in  1  pulse: begin a new set (honoured only in IDLE).
- in_valid  in  1  feature beat valid.
- in_ready  out  1  feeder accepts feature this cycle.
- in_feat  in  FEAT_W  raw feature value.
- in_last  in  1  marks last feature of a sample.
- im_value  out  DIM  level hypervector.
- im_pos  out  DIM  position hypervector.
- smp_en  out  1  im_value/im_pos valid for the sample encoder.
- smp_clr  out  1  clear sample encoder.
- set_clr  out  1  clear set encoder.
- busy  out  1  set in progress (state != IDLE).
- smp_idx  out  clog2(SET_SIZE)  current sample index within set.

Behaviour:
- Reset: clk edge with rst=1 forces state IDLE and clears feat_idx, smp_idx and gap counter. All outputs are 0 (im_value, im_pos, smp_en, smp_clr, set_clr, busy, in_ready). Reset mid-sample abandons it; no clear pulse is emitted.
- FSM states: IDLE, CLR, STREAM, GAP.
- IDLE: in_ready=0. set_start=1 → CLR with smp_idx=0.
- CLR: exactly one cycle. smp_clr=1. set_clr=1 iff smp_idx==0. in_ready=0. → STREAM with feat_idx=0.
- STREAM: in_ready=1. Each handshake (in_valid&in_ready) with feature index i produces registered outputs one cycle later (latency 1):
  - smp_en=1.
  - lvl = in_feat >> (FEAT_W − log2(LEVELS)).
  - STEP = DIM/(2·LEVELS), integer floor.
  - im_value = LVL_SEED XOR mask, where mask has bits [lvl·STEP−1:0] set (mask=0 for lvl=0).
  - im_pos = POS_SEED rotated left by i mod DIM.
  - No handshake → smp_en=0 next cycle; im_value/im_pos hold. Bubbles are legal.
- Handshake with feat_idx==FEAT_NUM−1 → GAP, feat_idx=0. Otherwise feat_idx++.
- GAP: in_ready=0 for GAP_CYC cycles. Then:
  - if smp_idx==SET_SIZE−1 → IDLE, smp_idx=0;
  - else smp_idx++ → CLR.
- smp_clr, set_clr and smp_en are never high in the same cycle.
- in_last is advisory. The FEAT_NUM counter alone ends a sample.
- set_start outside IDLE is ignored.

Optional Feature:
- Macro HV_FEEDER_PROTO_CHK_EN.
- Defined: adds output proto_err (1 bit, reset 0, sticky until rst). Sets on either:
  - handshake with in_last=1 and feat_idx≠FEAT_NUM−1, or
  - handshake with in_last=0 and feat_idx==FEAT_NUM−1.
  - Sequencing is unchanged.
- Undefined: no proto_err port; in_last unused.

Test Plan:
1. Reset + idle (DIM=16, LEVELS=4, FEAT_W=8, FEAT_NUM=4, SET_SIZE=2, GAP_CYC=2): hold rst 3 cycles, no set_start → all outputs 0, busy=0, in_ready=0.
2. Level mapping (STEP=2, LVL_SEED=16'h0000): in_feat = 8'h00, 8'h40, 8'h80, 8'hFF → im_value = 16'h0000, 16'h0003, 16'h000F, 16'h003F one cycle after each handshake, with smp_en=1.
3. Position rotation (POS_SEED=16'h0001): features 0..3 accepted back-to-back → im_pos = 16'h0001, 0002, 0004, 0008.
4. Set sequencing: set_start, then in_valid held 1 → cycle sequence smp_clr=1 & set_clr=1, 4×smp_en, 2 GAP cycles, smp_clr=1 & set_clr=0, 4×smp_en, 2 GAP cycles, then IDLE with busy=0. Total 14 cycles after set_start.
5. Bubbles and mid-operation reset: in_valid toggles 1,0,1 → smp_en follows 1,0,1 delayed by 1 cycle, feat_idx advances only on handshakes. rst during 2nd feature → next cycle IDLE, all outputs 0; a new set_start restarts with set_clr=1.
6. HV_FEEDER_PROTO_CHK_EN: in_last=1 on feature index 1 → proto_err=1 next cycle and stays 1 across the rest of the set; sequencing identical to test 4.
